// File: rtl/barrett_for_691.sv
// Purpose : x mod 691 for a 19-bit unsigned operand by Barrett reduction (GF(691) post-multiply).
// Latency : 3 cycles, one operand per clock, valid-qualified, in-order.
// Backpres: none; din_valid gaps propagate as dout_valid gaps.
// Option  : define BARRETT_691_RANGE_FLAG_EN to add dout_oor (operand >= 691*691).

module barrett_for_691 (
    input  logic        clk,
    input  logic        rst,
    input  logic        din_valid,
    input  logic [18:0] din_a,
    output logic        dout_valid,
    output logic [9:0]  dout_r
`ifdef BARRETT_691_RANGE_FLAG_EN
    ,
    output logic        dout_oor
`endif
);

    // Modulus, its bit length, and the Barrett constant floor(2^(2K)/P).
    localparam int P    = 691;
    localparam int K    = 10;
    localparam int M    = 1517;
    // Largest product of two canonical residues is (P-1)^2; P*P is the first
    // operand outside that domain.
    localparam int P_SQ = P * P;

    // ------------------------------------------------------------------
    // Stage 1: estimate the quotient numerator.
    // q1 keeps only the top bits of x (x >> (K-1)); multiplying by M gives
    // q2, which after the stage-2 shift approximates floor(x/P) from below
    // by at most 2.
    // ------------------------------------------------------------------
    logic [9:0]  q1_c;
    logic [20:0] q2_c;

    logic        v_s1;
    logic [18:0] x_s1;
    logic [20:0] q2_s1;

    // Constant multiply by M on the truncated operand.
    always_comb begin
        q1_c = 10'(din_a >> (K - 1));
        q2_c = 21'(q1_c) * 21'(M);
    end

    // Register the quotient estimate together with the original operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_s1  <= 1'b0;
            x_s1  <= '0;
            q2_s1 <= '0;
        end else begin
            v_s1  <= din_valid;
            x_s1  <= din_a;
            q2_s1 <= q2_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: partial remainder.
    // q3 = q2 >> (K+1) is the quotient estimate; r0 = x - q3*P is kept at
    // full 21-bit width. Because q3 never exceeds the true quotient and
    // trails it by at most 2, r0 lies in [0, 3P).
    // ------------------------------------------------------------------
    logic [20:0] q3_c;
    logic [20:0] prod_c;
    logic [20:0] r0_c;

    logic        v_s2;
    logic [20:0] r0_s2;

    // Constant multiply by P and the subtraction from the operand.
    always_comb begin
        q3_c   = q2_s1 >> (K + 1);
        prod_c = q3_c * 21'(P);
        r0_c   = 21'(x_s1) - prod_c;
    end

    // Register the partial remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_s2  <= 1'b0;
            r0_s2 <= '0;
        end else begin
            v_s2  <= v_s1;
            r0_s2 <= r0_c;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final correction, at most two subtractions of P folded into
    // a single select of 0, P or 2P.
    // The comparisons look at every bit of r0; the subtraction itself is
    // done in 10 bits only. That is exact: the true result is below P < 1024,
    // so arithmetic modulo 1024 yields it directly (2P reduces to 358 there).
    // ------------------------------------------------------------------
    logic [9:0] sub_c;
    logic [9:0] res_c;

    // Pick the correction amount and form the canonical residue.
    always_comb begin
        sub_c = '0;
        if (r0_s2 >= 21'(2 * P)) begin
            sub_c = 10'(2 * P);
        end else if (r0_s2 >= 21'(P)) begin
            sub_c = 10'(P);
        end
        res_c = r0_s2[9:0] - sub_c;
    end

    // Output register: the residue only updates on a valid result and
    // otherwise holds the last one, so dout_r never glitches during gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_r     <= '0;
        end else begin
            dout_valid <= v_s2;
            if (v_s2) begin
                dout_r <= res_c;
            end
        end
    end

`ifdef BARRETT_691_RANGE_FLAG_EN
    // ------------------------------------------------------------------
    // Out-of-range flag: the operand could not have come from a product of
    // two residues. Computed at the input and carried alongside the data so
    // it lines up with dout_valid; like dout_r it holds during gaps.
    // ------------------------------------------------------------------
    logic oor_s1;
    logic oor_s2;

    // Carry the range flag down the same three stages as the operand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_s1   <= 1'b0;
            oor_s2   <= 1'b0;
            dout_oor <= 1'b0;
        end else begin
            oor_s1 <= (din_a >= 19'(P_SQ));
            oor_s2 <= oor_s1;
            if (v_s2) begin
                dout_oor <= oor_s2;
            end
        end
    end
`endif

endmodule

// File: tb/tb_barrett_for_691.sv
// Bench for barrett_for_691: directed boundaries, bubbles, async reset, random stream.
// Expected residues come from plain x % 691 on a queue of presented operands.
// A per-cycle compare process checks every output cycle; directed literals pin the model.

module tb_barrett_for_691;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic [18:0] din_a = '0;
    logic        dout_valid;
    logic [9:0]  dout_r;
`ifdef BARRETT_691_RANGE_FLAG_EN
    logic        dout_oor;
`endif

    barrett_for_691 dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_a      (din_a),
        .dout_valid (dout_valid),
        .dout_r     (dout_r)
`ifdef BARRETT_691_RANGE_FLAG_EN
        ,
        .dout_oor   (dout_oor)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each accepted operand is tagged with the cycle it was presented in;
    // its residue must appear exactly 3 cycles later.
    typedef struct {
        int tag;
        int x;
    } op_t;

    op_t q[$];
    int  cyc    = 0;
    int  last_r = 0;

    always @(posedge clk) begin
        if (!rst && din_valid) q.push_back('{cyc, int'(din_a)});
        cyc = cyc + 1;
    end

    // Reset throws away everything in flight and zeroes the held residue.
    always @(posedge rst) begin
        q.delete();
        last_r = 0;
    end

    always @(negedge clk) begin : compare
        bit ev;
        int e;
        if (rst) begin
            chk("rst_valid", int'(dout_valid), 0);
            chk("rst_r", int'(dout_r), 0);
`ifdef BARRETT_691_RANGE_FLAG_EN
            chk("rst_oor", int'(dout_oor), 0);
`endif
        end else begin
            if (q.size() > 0 && q[0].tag < cyc - 3) begin
                chk("lost_result_tag", q[0].tag, cyc - 3);
                void'(q.pop_front());
            end
            ev = (q.size() > 0 && q[0].tag == cyc - 3);
            chk("valid", int'(dout_valid), int'(ev));
            if (ev) begin
                e = q[0].x % 691;
                chk("residue", int'(dout_r), e);
`ifdef BARRETT_691_RANGE_FLAG_EN
                chk("oor", int'(dout_oor), int'(q[0].x >= 477481));
`endif
                last_r = e;
                void'(q.pop_front());
            end else begin
                chk("hold", int'(dout_r), last_r);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single operand; check the literal result 3 cycles after presentation.
    task automatic directed(input int x, input int r, input int oor);
        din_valid = 1'b1;
        din_a     = 19'(x);
        step();
        din_valid = 1'b0;
        step();
        step();
        chk($sformatf("dir_valid_%0d", x), int'(dout_valid), 1);
        chk($sformatf("dir_r_%0d", x), int'(dout_r), r);
`ifdef BARRETT_691_RANGE_FLAG_EN
        chk($sformatf("dir_oor_%0d", x), int'(dout_oor), oor);
`else
        if (oor < 0) $display("unexpected flag argument");
`endif
        step();
    endtask

    int dx[10] = '{691, 1381, 1382, 477480, 477481, 524287, 0, 690, 1000, 2072};
    int dr[10] = '{0,   690,  0,    690,    0,      509,    0, 690, 309,  690};
    int dof[10] = '{0,  0,    0,    0,      1,      1,      0, 0,   0,    0};

    int bv[3]  = '{1000, 2000, 3000};
    int bexp[9] = '{0, 0, 0, 309, 309, 618, 618, 236, 236};

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", int'(dout_valid), 0);
        chk("reset_r", int'(dout_r), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Identity sweep at full rate.
        for (int i = 0; i < 691; i++) begin
            din_valid = 1'b1;
            din_a     = 19'(i);
            step();
        end
        din_valid = 1'b0;
        repeat (4) step();

        // Multiples, boundaries, maximum input.
        for (int i = 0; i < 10; i++) directed(dx[i], dr[i], dof[i]);
        repeat (2) step();

        // Bubbles: operand, idle, operand, idle, ...
        for (int w = 0; w < 9; w++) begin
            if (w < 6 && (w % 2) == 0) begin
                din_valid = 1'b1;
                din_a     = 19'(bv[w / 2]);
            end else begin
                din_valid = 1'b0;
            end
            if (w >= 3) begin
                chk($sformatf("bubble_valid_w%0d", w), int'(dout_valid), int'((w % 2) == 1));
                chk($sformatf("bubble_r_w%0d", w), int'(dout_r), bexp[w]);
            end
            step();
        end
        din_valid = 1'b0;
        repeat (3) step();

        // Reset mid-flight, asserted between clock edges.
        for (int i = 0; i < 3; i++) begin
            din_valid = 1'b1;
            din_a     = 19'(5000 + 1000 * i);
            step();
        end
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(dout_valid), 0);
        chk("async_rst_r", int'(dout_r), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step();
        chk("post_rst_valid", int'(dout_valid), 0);
        chk("post_rst_r", int'(dout_r), 0);

        // Random operands at full rate.
        for (int i = 0; i < 10000; i++) begin
            din_valid = 1'b1;
            din_a     = 19'($urandom_range(0, 524287));
            step();
        end
        // Random operands with random gaps.
        for (int i = 0; i < 500; i++) begin
            din_valid = 1'($urandom_range(0, 1));
            din_a     = 19'($urandom_range(0, 524287));
            step();
        end
        din_valid = 1'b0;
        repeat (5) step();
        chk("drain_pending", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
